multicycle_main_control: RTL
============================

Name: multicycle_main_control

Overview:
- Moore-style main control FSM for the multicycle MIPS datapath.
- Sits directly upstream of the ALU function decoder and drives its 2-bit ALUOp: 00 = add, 01 = sub, 10 = decode funct.
- Sequences fetch, decode, execute, memory and writeback for R-type, lw, sw, beq, addi and j.
- Stalls on a memory-ready handshake.

Parameters:
- none (opcode encodings fixed: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  instruction opcode, valid from DECODE onward (from IR)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register: 0 = rt, 1 = rd
- MemtoReg  out  1  writeback source: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- ALUOp  out  2  to ALU function decoder
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_en  out  1  PC load = PCWrite | (Branch & zero)
- illegal  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- Single state register updated on rising clk.
- rst=1 at an edge: state <= FETCH.
- While rst=1, MemWrite, IRWrite, RegWrite, pc_en and illegal are forced to 0. Other outputs follow the FETCH decode.
- All outputs are decoded from the state only, except pc_en and the mem_ready gating below. Each output defaults to 0 in every state unless listed.
- States and encodings:
  - FETCH 0: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite and PCWrite equal mem_ready. Stay while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE 1: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target). Next state by op: lw/sw -> MEMADR, R -> EXECUTE, beq -> BRANCH, addi -> ADDIEX, j -> JUMP. Any other op -> FETCH with illegal=1 for this cycle.
  - MEMADR 2: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMRD if op=lw, else MEMWR.
  - MEMRD 3: IorD=1. Hold until mem_ready=1, then MEMWB.
  - MEMWB 4: RegDst=0, MemtoReg=1, RegWrite=1. Next FETCH.
  - MEMWR 5: IorD=1, MemWrite=1 held while waiting. Go to FETCH when mem_ready=1.
  - EXECUTE 6: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next ALUWB.
  - ALUWB 7: RegDst=1, MemtoReg=0, RegWrite=1. Next FETCH.
  - BRANCH 8: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Next FETCH.
  - ADDIEX 9: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDIWB.
  - ADDIWB 10: RegDst=0, MemtoReg=0, RegWrite=1. Next FETCH.
  - JUMP 11: PCSrc=10, PCWrite=1. Next FETCH.
- Encodings 12-15 are unreachable. If entered, go to FETCH next cycle with all enables 0.
- pc_en is combinational: PCWrite | (Branch & zero). A zero glitch outside BRANCH has no effect.
- Latency with mem_ready held high, counted in cycles from FETCH to the next FETCH:
  - R, addi, sw: 4
  - lw: 5
  - beq, j: 3
  - illegal: 2
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle. No other state samples mem_ready.
- rst asserted mid-instruction (e.g. in MEMWR): MemWrite drops immediately, FETCH follows at the next edge, and no partial writeback occurs.

Test Plan:
- Reset, then R-type (op=000000), mem_ready=1 -> states 0,1,6,7,0. ALUOp=10 in EXECUTE. RegWrite=1 and RegDst=1 only in state 7.
- lw (100011) with mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. IorD=1 in state 3. MemtoReg=1 and RegWrite=1 in state 4.
- beq (000100): zero=1 -> pc_en=1 and PCSrc=01 in BRANCH, ALUOp=01. Repeat with zero=0 -> pc_en=0 in BRANCH.
- j (000010) -> states 0,1,11,0, with PCSrc=10 and pc_en=1 in state 11. Then sw (101011) -> MemWrite=1 only in state 5.
- Illegal op=111111 -> illegal=1 for exactly one cycle in DECODE, then FETCH. No RegWrite or MemWrite asserted.
- Assert rst during MEMWR with mem_ready=0 -> MemWrite=0 the same cycle, state=0 after the edge. FETCH with mem_ready=0 holds IRWrite=0 and pc_en=0.

Source files
------------

// File: rtl/multicycle_main_control_if.sv
// Control bus between the multicycle main control FSM and the MIPS datapath.
// The control FSM sits on the master side; the datapath sits on the slave side.
interface multicycle_main_control_if;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       pc_en;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, zero, mem_ready,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, pc_en, illegal, state
  );

  modport slave (
    output op, zero, mem_ready,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, pc_en, illegal, state
  );
endinterface

// File: rtl/multicycle_main_control.sv
// Moore main control FSM for the multicycle MIPS datapath (R, lw, sw, beq, addi, j).
// Outputs decode from the state register; only enables and pc_en see mem_ready, zero and rst.
module multicycle_main_control (
  input  logic                           clk,
  input  logic                           rst,
  multicycle_main_control_if.master      bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Unreachable encodings 12-15 fall into the default arm and recover to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  logic       iord_d, memwrite_d, irwrite_d, regdst_d, memtoreg_d, regwrite_d;
  logic       alusrca_d, pcwrite_d, branch_d, illegal_d, op_legal;
  logic [1:0] alusrcb_d, aluop_d, pcsrc_d;

  always_comb begin
    case (bus.op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      default:                                   op_legal = 1'b0;
    endcase
  end

  always_comb begin
    iord_d     = 1'b0;
    memwrite_d = 1'b0;
    irwrite_d  = 1'b0;
    regdst_d   = 1'b0;
    memtoreg_d = 1'b0;
    regwrite_d = 1'b0;
    alusrca_d  = 1'b0;
    alusrcb_d  = 2'b00;
    aluop_d    = 2'b00;
    pcsrc_d    = 2'b00;
    pcwrite_d  = 1'b0;
    branch_d   = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb_d = 2'b01;
        irwrite_d = bus.mem_ready;
        pcwrite_d = bus.mem_ready;
      end
      S_DECODE: begin
        alusrcb_d = 2'b11;
        illegal_d = ~op_legal;
      end
      S_MEMADR: begin
        alusrca_d = 1'b1;
        alusrcb_d = 2'b10;
      end
      S_MEMRD:  iord_d = 1'b1;
      S_MEMWB: begin
        memtoreg_d = 1'b1;
        regwrite_d = 1'b1;
      end
      S_MEMWR: begin
        iord_d     = 1'b1;
        memwrite_d = 1'b1;
      end
      S_EXECUTE: begin
        alusrca_d = 1'b1;
        aluop_d   = 2'b10;
      end
      S_ALUWB: begin
        regdst_d   = 1'b1;
        regwrite_d = 1'b1;
      end
      S_BRANCH: begin
        alusrca_d = 1'b1;
        aluop_d   = 2'b01;
        pcsrc_d   = 2'b01;
        branch_d  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca_d = 1'b1;
        alusrcb_d = 2'b10;
      end
      S_ADDIWB: regwrite_d = 1'b1;
      S_JUMP: begin
        pcsrc_d   = 2'b10;
        pcwrite_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset must kill every side-effecting strobe in the same cycle it is raised.
  assign bus.IorD     = iord_d;
  assign bus.MemWrite = memwrite_d & ~rst;
  assign bus.IRWrite  = irwrite_d & ~rst;
  assign bus.RegDst   = regdst_d;
  assign bus.MemtoReg = memtoreg_d;
  assign bus.RegWrite = regwrite_d & ~rst;
  assign bus.ALUSrcA  = alusrca_d;
  assign bus.ALUSrcB  = alusrcb_d;
  assign bus.ALUOp    = aluop_d;
  assign bus.PCSrc    = pcsrc_d;
  assign bus.pc_en    = (pcwrite_d | (branch_d & bus.zero)) & ~rst;
  assign bus.illegal  = illegal_d & ~rst;
  assign bus.state    = state_q;

endmodule
